// File: rtl/receptor_uart_param.sv
// UART receiver: oversampled 2-of-3 majority sampling, false-start rejection, optional parity (RX_PARITY_EN).
// Latency: rx_valid rises one clock after the decision tick of the last stop bit.
// Backpressure: one-entry holding register; frames arriving while it is full are dropped and flag overrun.
module receptor_uart_param #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9_600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_d,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] S_LO      = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_DEC     = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_END     = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    D_LAST    = 4'(DATA_BITS - 1);
    localparam logic [3:0]    P_LAST    = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                 state, state_nx;
    logic                   rx_m, rx_s;
    logic [TW-1:0]          tick_cnt;
    logic [SW-1:0]          s_cnt;
    logic [3:0]             bit_cnt;
    logic                   smp0, smp1;
    logic [DATA_BITS-1:0]   sh_reg;
    logic                   ferr_acc, perr_acc;
    logic                   tick, dec_tick, end_tick, maj, last_data, last_stop, stop_err;
    logic                   start_clr, shift_en, stop_dec, deliver, bit_inc, bit_clr;
    logic                   hs, load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_d;
            rx_s <= rx_m;
        end
    end

    assign tick      = (state != ST_IDLE) && (tick_cnt == TICK_LAST);
    assign dec_tick  = tick && (s_cnt == S_DEC);
    assign end_tick  = tick && (s_cnt == S_END);
    // The third vote is the live synchronised sample taken on the decision tick itself.
    assign maj       = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
    assign last_data = (bit_cnt == D_LAST);
    assign last_stop = (bit_cnt == P_LAST);
    assign stop_err  = ferr_acc | ~maj | perr_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (!rx_s) state_nx = ST_START;
            ST_START:  if (dec_tick && maj) state_nx = ST_IDLE;
                       else if (end_tick)   state_nx = ST_DATA;
`ifdef RX_PARITY_EN
            ST_DATA:   if (end_tick && last_data) state_nx = ST_PARITY;
            ST_PARITY: if (end_tick) state_nx = ST_STOP;
`else
            ST_DATA:   if (end_tick && last_data) state_nx = ST_STOP;
`endif
            ST_STOP:   if (dec_tick && last_stop) state_nx = stop_err ? ST_BREAK : ST_IDLE;
            ST_BREAK:  if (rx_s) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

`ifdef RX_PARITY_EN
    logic par_en;
`endif

    always_comb begin
        start_clr = 1'b0;
        shift_en  = 1'b0;
        stop_dec  = 1'b0;
        deliver   = 1'b0;
        bit_inc   = 1'b0;
        bit_clr   = 1'b0;
`ifdef RX_PARITY_EN
        par_en    = 1'b0;
`endif
        case (state)
            ST_IDLE:   start_clr = !rx_s;
            ST_DATA: begin
                shift_en = dec_tick;
                bit_inc  = end_tick && !last_data;
                bit_clr  = end_tick && last_data;
            end
`ifdef RX_PARITY_EN
            ST_PARITY: par_en = dec_tick;
`endif
            ST_STOP: begin
                stop_dec = dec_tick;
                deliver  = dec_tick && last_stop;
                bit_inc  = end_tick;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            s_cnt    <= '0;
            bit_cnt  <= '0;
            smp0     <= 1'b1;
            smp1     <= 1'b1;
            sh_reg   <= '0;
            ferr_acc <= 1'b0;
        end else begin
            if (start_clr)             tick_cnt <= '0;
            else if (state != ST_IDLE) tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (start_clr)  s_cnt <= '0;
            else if (tick)  s_cnt <= (s_cnt == S_END) ? '0 : s_cnt + SW'(1);
            if (start_clr || bit_clr) bit_cnt <= '0;
            else if (bit_inc)         bit_cnt <= bit_cnt + 4'd1;
            if (tick && s_cnt == S_LO)  smp0 <= rx_s;
            if (tick && s_cnt == S_MID) smp1 <= rx_s;
            if (shift_en) sh_reg <= {maj, sh_reg[DATA_BITS-1:1]};
            if (start_clr)              ferr_acc <= 1'b0;
            else if (stop_dec && !maj)  ferr_acc <= 1'b1;
        end
    end

`ifdef RX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         perr_acc <= 1'b0;
        else if (start_clr) perr_acc <= 1'b0;
        else if (par_en)    perr_acc <= ^sh_reg ^ maj ^ PAR_SENSE;
    end
`else
    logic par_unused;
    assign par_unused = (PARITY_ODD != 0);
    assign perr_acc   = 1'b0;
`endif

    assign hs   = rx_valid && rx_ready;
    assign load = deliver && (!rx_valid || rx_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data   <= '0;
            frame_err <= 1'b0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                rx_data   <= sh_reg;
                frame_err <= ferr_acc | ~maj;
                rx_valid  <= 1'b1;
            end else if (hs) begin
                rx_valid  <= 1'b0;
            end
            if (hs)                       overrun <= 1'b0;
            else if (deliver && rx_valid) overrun <= 1'b1;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    parity_err <= 1'b0;
        else if (load) parity_err <= perr_acc;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_receptor_uart_param.sv
// Directed bench for receptor_uart_param; fast line (2 clocks per tick, 32 clocks per bit).
module tb_receptor_uart_param;

    localparam int BIT = 32;
`ifdef RX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_d = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun;

    receptor_uart_param #(
        .CLK_FREQ(3_200_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
        .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .reset(reset), .rx_d(rx_d),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int vcyc  = 0;
    logic [9:0] hs_q[$];

    always @(negedge clk) begin
        if (rx_valid) vcyc++;
        if (rx_valid && rx_ready) hs_q.push_back({parity_err, frame_err, rx_data});
    end

    task automatic drive_bit(input logic v);
        @(negedge clk);
        rx_d = v;
        repeat (BIT - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (HAS_PAR) drive_bit(p);
        drive_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        @(negedge clk);
        rx_d = 1'b1;
        repeat (n * BIT - 1) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2 rx_ready = v;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if (rx_valid !== 1'b0)   begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        total++; if (rx_data !== 8'h00)   begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
        total++; if (overrun !== 1'b0)    begin bad++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
        @(negedge clk);
        reset = 1'b1;
        repeat (BIT) @(negedge clk);
        total++; if (rx_valid !== 1'b0)   begin bad++; $display("FAIL idle_valid got=%b exp=0", rx_valid); end
    endtask

    task automatic test_basic;
        int lat, v0, lo, hi;
        logic [9:0] e;
        set_ready(1'b1);
        hs_q.delete();
        v0  = vcyc;
        lat = 0;
        fork
            send_frame(8'h55, ^8'h55, 1'b1);
            begin
                @(negedge clk);
                while (!rx_valid && lat < 2000) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        idle_bits(2);
        lo = 303 + (HAS_PAR ? BIT : 0);
        hi = 315 + (HAS_PAR ? BIT : 0);
        total++; if (lat < lo || lat > hi) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d..%0d", lat, lo, hi); end
        total++; if (vcyc - v0 !== 1)      begin bad++; $display("FAIL basic_vcycles got=%0d exp=1", vcyc - v0); end
        total++; if (hs_q.size() !== 1)    begin bad++; $display("FAIL basic_count got=%0d exp=1", hs_q.size()); end
        e = (hs_q.size() > 0) ? hs_q[0] : 10'h3ff;
        total++; if (e !== 10'h055)        begin bad++; $display("FAIL basic_frame got=%h exp=055", e); end
        total++; if (overrun !== 1'b0)     begin bad++; $display("FAIL basic_ovr got=%b exp=0", overrun); end
    endtask

    task automatic test_false_start;
        int v0;
        logic [9:0] e;
        hs_q.delete();
        v0 = vcyc;
        @(negedge clk);
        rx_d = 1'b0;
        repeat (6) @(negedge clk);
        rx_d = 1'b1;
        idle_bits(2);
        total++; if (vcyc !== v0)       begin bad++; $display("FAIL glitch_valid got=%0d exp=%0d", vcyc, v0); end
        total++; if (hs_q.size() !== 0) begin bad++; $display("FAIL glitch_count got=%0d exp=0", hs_q.size()); end
        send_frame(8'hC3, ^8'hC3, 1'b1);
        idle_bits(2);
        total++; if (hs_q.size() !== 1) begin bad++; $display("FAIL after_glitch_count got=%0d exp=1", hs_q.size()); end
        e = (hs_q.size() > 0) ? hs_q[0] : 10'h3ff;
        total++; if (e !== 10'h0C3)     begin bad++; $display("FAIL after_glitch_frame got=%h exp=0c3", e); end
    endtask

    task automatic test_frame_err;
        logic [9:0] e;
        hs_q.delete();
        send_frame(8'hA3, ^8'hA3, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        total++; if (hs_q.size() !== 1) begin bad++; $display("FAIL ferr_count_low got=%0d exp=1", hs_q.size()); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ferr_valid_low got=%b exp=0", rx_valid); end
        idle_bits(2);
        total++; if (hs_q.size() !== 1) begin bad++; $display("FAIL ferr_count_high got=%0d exp=1", hs_q.size()); end
        e = (hs_q.size() > 0) ? hs_q[0] : 10'h000;
        total++; if (e !== 10'h1A3)     begin bad++; $display("FAIL ferr_frame got=%h exp=1a3", e); end
    endtask

    task automatic test_overrun;
        logic [9:0] e;
        hs_q.delete();
        set_ready(1'b0);
        send_frame(8'h11, ^8'h11, 1'b1);
        send_frame(8'h22, ^8'h22, 1'b1);
        idle_bits(1);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", rx_valid); end
        total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL ovr_data got=%h exp=11", rx_data); end
        total++; if (overrun !== 1'b1)  begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        set_ready(1'b1);
        set_ready(1'b0);
        @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_valid_after got=%b exp=0", rx_valid); end
        total++; if (overrun !== 1'b0)  begin bad++; $display("FAIL ovr_flag_after got=%b exp=0", overrun); end
        e = (hs_q.size() == 1) ? hs_q[0] : 10'h3ff;
        total++; if (e !== 10'h011)     begin bad++; $display("FAIL ovr_handshake got=%h n=%0d exp=011", e, hs_q.size()); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] e0, e1;
        hs_q.delete();
        set_ready(1'b1);
        send_frame(8'h5A, ^8'h5A, 1'b1);
        send_frame(8'hA5, ^8'hA5, 1'b1);
        idle_bits(2);
        total++; if (hs_q.size() !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", hs_q.size()); end
        e0 = (hs_q.size() > 0) ? hs_q[0] : 10'h3ff;
        e1 = (hs_q.size() > 1) ? hs_q[1] : 10'h3ff;
        total++; if (e0 !== 10'h05A)    begin bad++; $display("FAIL b2b_first got=%h exp=05a", e0); end
        total++; if (e1 !== 10'h0A5)    begin bad++; $display("FAIL b2b_second got=%h exp=0a5", e1); end
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity;
        logic [9:0] e;
        hs_q.delete();
        set_ready(1'b1);
        send_frame(8'h07, 1'b0, 1'b1);
        idle_bits(2);
        e = (hs_q.size() > 0) ? hs_q[0] : 10'h000;
        total++; if (e !== 10'h207) begin bad++; $display("FAIL par_bad got=%h exp=207", e); end
        hs_q.delete();
        send_frame(8'h07, 1'b1, 1'b1);
        idle_bits(2);
        e = (hs_q.size() > 0) ? hs_q[0] : 10'h3ff;
        total++; if (e !== 10'h007) begin bad++; $display("FAIL par_good got=%h exp=007", e); end
    endtask
`endif

    task automatic test_reset_mid;
        logic [7:0] d;
        logic [9:0] e;
        d = 8'h3C;
        set_ready(1'b0);
        send_frame(8'h99, ^8'h99, 1'b1);
        idle_bits(1);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%b exp=1", rx_valid); end
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        @(negedge clk);
        rx_d = d[4];
        repeat (15) @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_mid_data got=%h exp=00", rx_data); end
        total++; if (overrun !== 1'b0)  begin bad++; $display("FAIL rst_mid_ovr got=%b exp=0", overrun); end
        @(negedge clk);
        rx_d = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (BIT) @(negedge clk);
        hs_q.delete();
        set_ready(1'b1);
        send_frame(d, ^d, 1'b1);
        idle_bits(2);
        e = (hs_q.size() == 1) ? hs_q[0] : 10'h3ff;
        total++; if (e !== 10'h03C)     begin bad++; $display("FAIL rst_after_frame got=%h n=%0d exp=03c", e, hs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_back_to_back();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
